// File: rtl/s_p.sv
// s_p: serial-to-parallel converter. Collects 16-sample frames of 34-bit
// complex samples into a ping-pong register bank and emits each completed
// frame as four beats of four lanes (lane L of beat k = slot k + 4L).
// Optional build macro S_P_BITREV_EN: when defined, sample n is stored in
// slot bitrev4(n) instead of slot n.
module s_p (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [33:0]  data_in_0,
  input  logic         s_p_flag_in,
  input  logic         sync_in,
  output logic [135:0] data_out_0,
  output logic         s_p_flag_out,
  output logic [1:0]   beat_idx,
  output logic         frame_err
);

  localparam int unsigned W     = 34;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LANES = 4;

  // Two frame banks; bank contents carry no reset.
  logic [W-1:0] bank0_mem [DEPTH];
  logic [W-1:0] bank1_mem [DEPTH];

  // Write side state
  logic [3:0] wr_cnt_d, wr_cnt_q;
  logic       wr_bank_d, wr_bank_q;

  // Read side state
  logic       rd_active_d, rd_active_q;
  logic       rd_bank_d, rd_bank_q;
  logic [1:0] beat_d, beat_q;

  // Registered outputs
  logic [W*LANES-1:0] data_out_d, data_out_q;
  logic               flag_out_d, flag_out_q;
  logic [1:0]         beat_idx_d, beat_idx_q;
  logic               frame_err_d, frame_err_q;

  // Combinational helpers
  logic       resync;
  logic       frame_done;
  logic [3:0] wr_idx;
  logic [3:0] wr_slot;
  logic [3:0] rd_slot;

  // Maps a sample index to its storage slot.
  function automatic logic [3:0] slot_of(input logic [3:0] n);
`ifdef S_P_BITREV_EN
    return {n[0], n[1], n[2], n[3]};
`else
    return n;
`endif
  endfunction

  // Next-state logic for the write counter, bank selection, read sequencer
  // and registered outputs.
  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    resync      = 1'b0;
    frame_done  = 1'b0;
    wr_idx      = wr_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    wr_bank_d   = wr_bank_q;
    rd_active_d = rd_active_q;
    rd_bank_d   = rd_bank_q;
    beat_d      = beat_q;
    flag_out_d  = 1'b0;
    beat_idx_d  = 2'd0;
    data_out_d  = data_out_q;
    rd_slot     = 4'd0;

    // A sync on a mid-frame sample restarts the frame at index 0.
    if (s_p_flag_in) begin
      resync     = sync_in && (wr_cnt_q != 4'd0);
      wr_idx     = resync ? 4'd0 : wr_cnt_q;
      wr_cnt_d   = wr_idx + 4'd1;
      frame_done = (wr_idx == 4'd15);
    end
    wr_slot     = slot_of(wr_idx);
    frame_err_d = resync;

    // Present the current beat of the read bank.
    if (rd_active_q) begin
      flag_out_d = 1'b1;
      beat_idx_d = beat_q;
      for (int l = 0; l < int'(LANES); l++) begin
        rd_slot = {2'(l), beat_q};
        data_out_d[W*l +: W] = rd_bank_q ? bank1_mem[rd_slot] : bank0_mem[rd_slot];
      end
    end

    // Frame completion hands the filled bank to the reader.
    if (frame_done) begin
      wr_bank_d   = ~wr_bank_q;
      rd_bank_d   = wr_bank_q;
      rd_active_d = 1'b1;
      beat_d      = 2'd0;
    end else if (rd_active_q) begin
      beat_d = beat_q + 2'd1;
      if (beat_q == 2'd3) begin
        rd_active_d = 1'b0;
      end
    end
  end

  // Control and output registers with asynchronous reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q    <= 4'd0;
      wr_bank_q   <= 1'b0;
      rd_active_q <= 1'b0;
      rd_bank_q   <= 1'b0;
      beat_q      <= 2'd0;
      data_out_q  <= '0;
      flag_out_q  <= 1'b0;
      beat_idx_q  <= 2'd0;
      frame_err_q <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_active_q <= rd_active_d;
      rd_bank_q   <= rd_bank_d;
      beat_q      <= beat_d;
      data_out_q  <= data_out_d;
      flag_out_q  <= flag_out_d;
      beat_idx_q  <= beat_idx_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Sample storage into the current write bank.
  // NOTE: the bank arrays are deliberately not reset; every slot is written
  // before it is read, and leaving them reset-free keeps them plain registers.
  always_ff @(posedge clk) begin
    if (s_p_flag_in) begin
      if (wr_bank_q) begin
        bank1_mem[wr_slot] <= data_in_0;
      end else begin
        bank0_mem[wr_slot] <= data_in_0;
      end
    end
  end

  assign data_out_0   = data_out_q;
  assign s_p_flag_out = flag_out_q;
  assign beat_idx     = beat_idx_q;
  assign frame_err    = frame_err_q;

endmodule
